// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
//   state_e        : sequencer states
//   ERR_*          : err_code encodings
//   ADDR_ID/ADDR_TS: word addresses inside the system-ID slave
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StWaitId,
    StRdTs,
    StWaitTs,
    StCompare,
    StRetry,
    StDone
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ID      = 2'd2;
  localparam logic [1:0] ERR_TS      = 2'd3;

  localparam int unsigned ADDR_ID = 0;
  localparam int unsigned ADDR_TS = 1;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-read watchdog for the system-ID checker.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : zero the count (asserted on the edge entering a read state)
//   enable       : count this cycle (high while a read is outstanding)
//   expired      : high during the TIMEOUT_CYCLES-th enabled cycle since clear
module sysid_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q;

  // Saturates on the last cycle so expired stays high until the read is abandoned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LastCnt)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == LastCnt);

endmodule

// File: rtl/sysid_checker.sv
// Boot-time sequencer: reads the system-ID word and build timestamp over Avalon-MM,
// compares them against the build's expected values and reports pass/fail.
//   clock, reset        : clock and asynchronous active-high reset
//   start               : re-run pulse, honoured only in DONE
//   avm_*               : read-only Avalon-MM master port
//   busy, done, pass    : status; pass is valid while done is high
//   err_code            : 0 ok, 1 timeout, 2 ID mismatch, 3 timestamp mismatch
//   id_value, ts_value  : last captured words 0 and 1
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter int unsigned ADDR_W         = 1,
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1364720178,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [31:0]       avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  state_e            state_q, state_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              pass_q, pass_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       id_q, id_d;
  logic [31:0]       ts_q, ts_d;

  logic to_clear;
  logic to_enable;
  logic to_expired;

  sysid_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      retry_q <= '0;
      pass_q  <= 1'b0;
      err_q   <= ERR_OK;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    pass_d  = pass_q;
    err_d   = err_q;
    id_d    = id_q;
    ts_d    = ts_q;

    case (state_q)
      StIdle: state_d = StRdId;

      // An accepted read still counts as timed out if the window closes on
      // that edge: only captured data overrides expiry.
      StRdId: begin
        if (to_expired)            state_d = StRetry;
        else if (!avm_waitrequest) state_d = StWaitId;
      end

      StWaitId: begin
        if (avm_readdatavalid) begin
          id_d    = avm_readdata;
          state_d = StRdTs;
        end else if (to_expired) begin
          state_d = StRetry;
        end
      end

      StRdTs: begin
        if (to_expired)            state_d = StRetry;
        else if (!avm_waitrequest) state_d = StWaitTs;
      end

      StWaitTs: begin
        if (avm_readdatavalid) begin
          ts_d    = avm_readdata;
          state_d = StCompare;
        end else if (to_expired) begin
          state_d = StRetry;
        end
      end

      StCompare: begin
        state_d = StDone;
        if (id_q != EXPECTED_ID) begin
          pass_d = 1'b0;
          err_d  = ERR_ID;
        end else if (ts_q != EXPECTED_TS) begin
          pass_d = 1'b0;
          err_d  = ERR_TS;
        end else begin
          pass_d = 1'b1;
          err_d  = ERR_OK;
        end
      end

      StRetry: begin
        if (retry_q < RetryW'(MAX_RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = StRdId;
        end else begin
          pass_d  = 1'b0;
          err_d   = ERR_TIMEOUT;
          state_d = StDone;
        end
      end

      StDone: begin
        if (start) begin
          pass_d  = 1'b0;
          err_d   = ERR_OK;
          retry_d = '0;
          state_d = StRdId;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Restart the watchdog on every edge that enters a read-request state.
  assign to_clear  = ((state_d == StRdId) || (state_d == StRdTs)) && (state_d != state_q);
  assign to_enable = (state_q == StRdId) || (state_q == StWaitId) ||
                     (state_q == StRdTs) || (state_q == StWaitTs);

  // Decoded straight from the state register so reset drops the request at once.
  assign avm_read    = (state_q == StRdId) || (state_q == StRdTs);
  assign avm_address = (state_q == StRdTs) ? ADDR_W'(ADDR_TS) : ADDR_W'(ADDR_ID);

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign pass     = pass_q;
  assign err_code = err_q;
  assign id_value = id_q;
  assign ts_value = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: dut_a (default parameters) with a zero-wait,
// stallable slave, dut_b (TIMEOUT_CYCLES=8) with a slave of programmable response delay.
module tb_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1364720178;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- DUT A ----------------
  logic        start_a = 1'b0;
  logic        addr_a;
  logic        rd_a, wreq_a, rdv_a;
  logic [31:0] rdata_a;
  logic        busy_a, done_a, pass_a;
  logic [1:0]  err_a;
  logic [31:0] id_a, ts_a;

  logic [31:0] id_word = 32'd0;
  logic [31:0] ts_word = TS_OK;
  int          ts_stall = 0;

  sysid_checker dut_a (
    .clock            (clk),
    .reset            (rst),
    .start            (start_a),
    .avm_address      (addr_a),
    .avm_read         (rd_a),
    .avm_waitrequest  (wreq_a),
    .avm_readdatavalid(rdv_a),
    .avm_readdata     (rdata_a),
    .busy             (busy_a),
    .done             (done_a),
    .pass             (pass_a),
    .err_code         (err_a),
    .id_value         (id_a),
    .ts_value         (ts_a)
  );

  logic pend_a = 1'b0;
  logic paddr_a = 1'b0;
  int   stall_a = 0;
  int   acc_a0 = 0;
  int   acc_a1 = 0;
  logic [1:0] a_hist = 2'b11;
  logic prev_stall = 1'b0;
  logic prev_addr = 1'b0;
  int   viol = 0;

  assign wreq_a  = rd_a && (addr_a == 1'b1) && (stall_a < ts_stall);
  assign rdv_a   = pend_a;
  assign rdata_a = paddr_a ? ts_word : id_word;

  always @(posedge clk) begin
    pend_a <= rd_a && !wreq_a;
    if (rd_a && !wreq_a) begin
      paddr_a <= addr_a;
      a_hist  <= {a_hist[0], addr_a};
      if (addr_a) acc_a1 <= acc_a1 + 1;
      else        acc_a0 <= acc_a0 + 1;
    end
    if (!rd_a)       stall_a <= 0;
    else if (wreq_a) stall_a <= stall_a + 1;
    // Request must hold address and read while stalled.
    if (prev_stall && !(rd_a && (addr_a == prev_addr))) viol <= viol + 1;
    prev_stall <= rd_a && wreq_a;
    prev_addr  <= addr_a;
  end

  // ---------------- DUT B ----------------
  logic        addr_b;
  logic        rd_b, rdv_b;
  logic [31:0] rdata_b;
  logic        busy_b, done_b, pass_b;
  logic [1:0]  err_b;
  logic [31:0] id_b, ts_b;
  logic [3:0]  b_delay = 4'd1;
  logic [3:0]  bcnt = 4'd0;
  logic        baddr = 1'b0;
  int          acc_b0 = 0;
  int          acc_b1 = 0;

  sysid_checker #(
    .TIMEOUT_CYCLES(8),
    .MAX_RETRIES   (3)
  ) dut_b (
    .clock            (clk),
    .reset            (rst),
    .start            (1'b0),
    .avm_address      (addr_b),
    .avm_read         (rd_b),
    .avm_waitrequest  (1'b0),
    .avm_readdatavalid(rdv_b),
    .avm_readdata     (rdata_b),
    .busy             (busy_b),
    .done             (done_b),
    .pass             (pass_b),
    .err_code         (err_b),
    .id_value         (id_b),
    .ts_value         (ts_b)
  );

  // Response arrives b_delay cycles after acceptance; 0 means never.
  assign rdv_b   = (bcnt == 4'd1);
  assign rdata_b = baddr ? TS_OK : 32'd0;

  always @(posedge clk) begin
    if (rd_b) begin
      bcnt  <= b_delay;
      baddr <= addr_b;
      if (addr_b) acc_b1 <= acc_b1 + 1;
      else        acc_b0 <= acc_b0 + 1;
    end else if (bcnt != 4'd0) begin
      bcnt <= bcnt - 4'd1;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    int          stall;
    int          lat;
    logic        pass;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[5];

  int c0, c1, v0, edges, busy_bad;

  task automatic reset_and_release();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    check("reset_read", {31'd0, rd_a}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    c0 = acc_a0;
    c1 = acc_a1;
    v0 = viol;
    rst = 1'b0;
  endtask

  task automatic wait_done_a(input int bound);
    edges    = 0;
    busy_bad = 0;
    while (!done_a && edges < bound) begin
      @(posedge clk);
      #1;
      edges++;
      if (!done_a && !busy_a) busy_bad++;
    end
  endtask

  task automatic wait_done_b(input int bound);
    edges = 0;
    while (!done_b && edges < bound) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("b_done_in_time", {31'd0, done_b}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{id: 32'd0, ts: TS_OK,  stall: 0,  lat: 6,  pass: 1'b1, err: 2'd0};
    vecs[1] = '{id: 32'd5, ts: TS_OK,  stall: 0,  lat: 6,  pass: 1'b0, err: 2'd2};
    vecs[2] = '{id: 32'd0, ts: 32'd123, stall: 0, lat: 6,  pass: 1'b0, err: 2'd3};
    vecs[3] = '{id: 32'd5, ts: 32'd123, stall: 0, lat: 6,  pass: 1'b0, err: 2'd2};
    vecs[4] = '{id: 32'd0, ts: TS_OK,  stall: 10, lat: 16, pass: 1'b1, err: 2'd0};

    for (int i = 0; i < 5; i++) begin
      id_word  = vecs[i].id;
      ts_word  = vecs[i].ts;
      ts_stall = vecs[i].stall;
      reset_and_release();
      wait_done_a(100);
      check($sformatf("v%0d_latency", i), edges, vecs[i].lat);
      check($sformatf("v%0d_pass", i), {31'd0, pass_a}, {31'd0, vecs[i].pass});
      check($sformatf("v%0d_err", i), {30'd0, err_a}, {30'd0, vecs[i].err});
      check($sformatf("v%0d_id", i), id_a, vecs[i].id);
      check($sformatf("v%0d_ts", i), ts_a, vecs[i].ts);
      check($sformatf("v%0d_busy_low", i), {31'd0, busy_a}, 32'd0);
      check($sformatf("v%0d_busy_during", i), busy_bad, 0);
      check($sformatf("v%0d_reads_w0", i), acc_a0 - c0, 1);
      check($sformatf("v%0d_reads_w1", i), acc_a1 - c1, 1);
      check($sformatf("v%0d_addr_order", i), {30'd0, a_hist}, 32'd1);
      check($sformatf("v%0d_stall_stable", i), viol - v0, 0);
    end

    // ID mismatch, then no further reads, start ignored nowhere but honoured in DONE.
    id_word  = 32'd5;
    ts_word  = TS_OK;
    ts_stall = 0;
    reset_and_release();
    wait_done_a(100);
    check("mm_err", {30'd0, err_a}, 32'd2);
    check("mm_id", id_a, 32'd5);
    repeat (8) @(posedge clk);
    #1;
    check("mm_no_more_reads", (acc_a0 - c0) + (acc_a1 - c1), 2);
    check("mm_done_holds", {31'd0, done_a}, 32'd1);
    id_word = 32'd0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("restart_done_clear", {31'd0, done_a}, 32'd0);
    check("restart_busy", {31'd0, busy_a}, 32'd1);
    check("restart_err_clear", {30'd0, err_a}, 32'd0);
    wait_done_a(100);
    check("restart_pass", {31'd0, pass_a}, 32'd1);
    check("restart_err", {30'd0, err_a}, 32'd0);
    check("restart_id", id_a, 32'd0);

    // Reset while stalled in the timestamp read.
    ts_stall = 20;
    reset_and_release();
    edges = 0;
    while (!(rd_a && addr_a) && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("rst_mid_reached_rd_ts", {31'd0, rd_a && addr_a}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_read", {31'd0, rd_a}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    check("rst_mid_done", {31'd0, done_a}, 32'd0);
    check("rst_mid_pass", {31'd0, pass_a}, 32'd0);
    check("rst_mid_err", {30'd0, err_a}, 32'd0);
    check("rst_mid_id", id_a, 32'd0);
    check("rst_mid_ts", ts_a, 32'd0);
    ts_stall = 0;
    @(negedge clk);
    c0 = acc_a0;
    rst = 1'b0;
    wait_done_a(100);
    check("rst_mid_relatency", edges, 6);
    check("rst_mid_pass_after", {31'd0, pass_a}, 32'd1);
    check("rst_mid_restart_w0", acc_a0 - c0, 1);

    // Response lands on the expiry cycle: data wins, no retry.
    b_delay = 4'd7;
    reset_and_release();
    c0 = acc_b0;
    c1 = acc_b1;
    wait_done_b(300);
    check("coinc_pass", {31'd0, pass_b}, 32'd1);
    check("coinc_err", {30'd0, err_b}, 32'd0);
    check("coinc_w0_reads", acc_b0 - c0, 1);
    check("coinc_ts", ts_b, TS_OK);

    // One cycle too late: every attempt times out.
    b_delay = 4'd8;
    reset_and_release();
    c0 = acc_b0;
    wait_done_b(300);
    check("late_pass", {31'd0, pass_b}, 32'd0);
    check("late_err", {30'd0, err_b}, 32'd1);
    check("late_w0_reads", acc_b0 - c0, 4);

    // Silent slave.
    b_delay = 4'd0;
    reset_and_release();
    c0 = acc_b0;
    c1 = acc_b1;
    wait_done_b(300);
    check("silent_pass", {31'd0, pass_b}, 32'd0);
    check("silent_err", {30'd0, err_b}, 32'd1);
    check("silent_w0_reads", acc_b0 - c0, 4);
    check("silent_w1_reads", acc_b1 - c1, 0);
    check("silent_busy", {31'd0, busy_b}, 32'd0);
    // 4 attempts of 8 cycles plus 4 retry cycles, plus the auto-start edge.
    check("silent_latency", edges, 37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
